// File: rtl/pipe_reg_amisha.sv
// Stallable DEPTH-stage register pipeline with valid/ready, bubble collapsing, flush and occupancy count.
// Latency DEPTH-1 cycles from acceptance edge; in_ready falls only when every stage is full and out_ready is low.
module pipe_reg_amisha #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk_amisha,
    input  logic                       reset_n_amisha,
    input  logic                       flush_amisha,
    input  logic                       in_valid_amisha,
    output logic                       in_ready_amisha,
    input  logic [WIDTH-1:0]           in_data_amisha,
    output logic                       out_valid_amisha,
    input  logic                       out_ready_amisha,
    output logic [WIDTH-1:0]           out_data_amisha,
    output logic [$clog2(DEPTH+1)-1:0] count_amisha
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] en;
    logic [CW-1:0]    cnt;

    // A stage may load if it is empty or everything downstream of it can move.
    always_comb begin
        logic acc;
        acc = out_ready_amisha | ~v_q[DEPTH-1];
        en  = '0;
        en[DEPTH-1] = acc;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            acc   = ~v_q[k] | acc;
            en[k] = acc;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_amisha) begin
            v_d = '0;
        end else begin
            if (en[0]) begin
                v_d[0] = in_valid_amisha;
                if (in_valid_amisha) d_d[0] = in_data_amisha;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (en[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) d_d[k] = d_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= RESET_VALUE;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) cnt = cnt + CW'(v_q[k]);
    end

    assign in_ready_amisha  = en[0] & ~flush_amisha;
    assign out_valid_amisha = v_q[DEPTH-1];
    assign out_data_amisha  = d_q[DEPTH-1];
    assign count_amisha     = cnt;

endmodule

// File: tb/tb_pipe_reg_amisha.sv
// Bench for pipe_reg_amisha: a DEPTH=3 instance checked through a scoreboard, plus a DEPTH=1 corner instance.
module tb_pipe_reg_amisha;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=3 instance
    logic       rst_n   = 1'b0;
    logic       flush   = 1'b0;
    logic       in_vld  = 1'b0;
    logic [7:0] in_dat  = 8'h00;
    logic       out_rdy = 1'b0;
    logic       in_rdy;
    logic       out_vld;
    logic [7:0] out_dat;
    logic [1:0] cnt;

    // DEPTH=1 instance
    logic       a_rst_n   = 1'b0;
    logic       a_flush   = 1'b0;
    logic       a_in_vld  = 1'b0;
    logic [7:0] a_in_dat  = 8'h00;
    logic       a_out_rdy = 1'b0;
    logic       a_in_rdy;
    logic       a_out_vld;
    logic [7:0] a_out_dat;
    logic [0:0] a_cnt;

    pipe_reg_amisha #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) dut3 (
        .clk_amisha       (clk),
        .reset_n_amisha   (rst_n),
        .flush_amisha     (flush),
        .in_valid_amisha  (in_vld),
        .in_ready_amisha  (in_rdy),
        .in_data_amisha   (in_dat),
        .out_valid_amisha (out_vld),
        .out_ready_amisha (out_rdy),
        .out_data_amisha  (out_dat),
        .count_amisha     (cnt)
    );

    pipe_reg_amisha #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A)) dut1 (
        .clk_amisha       (clk),
        .reset_n_amisha   (a_rst_n),
        .flush_amisha     (a_flush),
        .in_valid_amisha  (a_in_vld),
        .in_ready_amisha  (a_in_rdy),
        .in_data_amisha   (a_in_dat),
        .out_valid_amisha (a_out_vld),
        .out_ready_amisha (a_out_rdy),
        .out_data_amisha  (a_out_dat),
        .count_amisha     (a_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int cyc    = 0;
    bit chk_lat = 1'b0;

    logic [7:0] exp_q[$];
    int         stamp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
            stamp_q.delete();
        end else begin
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", exp_q.size(), 1);
                end else begin
                    logic [7:0] e;
                    int         s;
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    chk("sb_data", out_dat, e);
                    // Acceptance at edge N, visible after edge N+2: three posedges after the accept sample.
                    if (chk_lat) chk("latency", cyc - s, 3);
                    n_out++;
                end
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(in_dat);
                stamp_q.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int out_before;

        // Reset with input presented
        rst_n = 1'b0; a_rst_n = 1'b0;
        in_vld = 1'b1; in_dat = 8'hAA;
        tick(); tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_out_dat", out_dat, 8'h00);
        chk("a_rst_out_dat", a_out_dat, 8'h5A);
        chk("a_rst_cnt", a_cnt, 0);
        rst_n = 1'b1; a_rst_n = 1'b1; in_vld = 1'b0;
        #1;
        chk("rst_in_rdy", in_rdy, 1);

        // Streaming
        out_rdy = 1'b1; chk_lat = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            in_vld = 1'b1; in_dat = 8'(w);
            tick();
            if (w >= 3) chk("stream_cnt", cnt, 3);
        end
        in_vld = 1'b0;
        repeat (4) tick();
        chk_lat = 1'b0;
        chk("stream_drained", out_vld, 0);
        chk("stream_words", n_out, 4);

        // Back-pressure
        out_rdy = 1'b0;
        in_vld = 1'b1; in_dat = 8'h11; tick();
        in_dat = 8'h22; tick();
        in_dat = 8'h33; tick();
        in_dat = 8'h44; #1;
        chk("bp_full_cnt", cnt, 3);
        chk("bp_in_rdy", in_rdy, 0);
        tick(); tick();
        chk("bp_hold_vld", out_vld, 1);
        chk("bp_hold_dat", out_dat, 8'h11);
        chk("bp_hold_cnt", cnt, 3);
        out_rdy = 1'b1; #1;
        chk("bp_full_ready", in_rdy, 1);
        tick();
        chk("bp_cnt_same", cnt, 3);
        in_vld = 1'b0;
        repeat (4) tick();
        chk("bp_words", n_out, 8);

        // Bubble collapse
        out_rdy = 1'b0;
        in_vld = 1'b1; in_dat = 8'h55; tick();
        in_vld = 1'b0; tick(); tick();
        in_vld = 1'b1; in_dat = 8'h66; #1;
        chk("bub_in_rdy", in_rdy, 1);
        tick();
        in_vld = 1'b0; #1;
        chk("bub_cnt", cnt, 2);
        chk("bub_head", out_dat, 8'h55);
        out_rdy = 1'b1;
        repeat (4) tick();
        chk("bub_words", n_out, 10);

        // Flush
        out_rdy = 1'b0;
        in_vld = 1'b1; in_dat = 8'h10; tick();
        in_dat = 8'h20; tick();
        in_dat = 8'h30; flush = 1'b1; #1;
        chk("fl_in_rdy", in_rdy, 0);
        out_before = n_out;
        tick();
        flush = 1'b0; in_vld = 1'b0; #1;
        chk("fl_cnt", cnt, 0);
        chk("fl_out_vld", out_vld, 0);
        out_rdy = 1'b1;
        repeat (4) tick();
        chk("fl_nothing_out", n_out, out_before);
        chk("sb_drained", exp_q.size(), 0);

        // Reset together with flush over a non-reset out_data
        chk("pre_rst_dat", out_dat, 8'h66);
        rst_n = 1'b0; flush = 1'b1; in_vld = 1'b1; in_dat = 8'h99;
        tick();
        chk("rf_out_dat", out_dat, 8'h00);
        chk("rf_cnt", cnt, 0);
        chk("rf_out_vld", out_vld, 0);
        rst_n = 1'b1; flush = 1'b0; in_vld = 1'b0;

        // DEPTH=1 corner
        a_out_rdy = 1'b1; a_in_vld = 1'b1; a_in_dat = 8'hA0; #1;
        chk("a_in_rdy0", a_in_rdy, 1);
        tick();
        chk("a_vld0", a_out_vld, 1);
        chk("a_dat0", a_out_dat, 8'hA0);
        chk("a_cnt0", a_cnt, 1);
        a_in_dat = 8'hA1; #1;
        chk("a_full_ready", a_in_rdy, 1);
        tick();
        chk("a_dat1", a_out_dat, 8'hA1);
        chk("a_cnt1", a_cnt, 1);
        a_in_dat = 8'hA2; tick();
        a_out_rdy = 1'b0; a_in_dat = 8'hA3; #1;
        chk("a_stall_rdy", a_in_rdy, 0);
        tick();
        chk("a_stall_dat", a_out_dat, 8'hA2);
        a_in_vld = 1'b0; a_out_rdy = 1'b1; tick();
        chk("a_empty_vld", a_out_vld, 0);
        chk("a_empty_cnt", a_cnt, 0);
        a_rst_n = 1'b0; a_flush = 1'b1; tick();
        chk("a_rf_dat", a_out_dat, 8'h5A);
        chk("a_rf_vld", a_out_vld, 0);
        a_rst_n = 1'b1; a_flush = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
